// File: rtl/core_pkg.sv
// Encodings shared between the control unit and the MEM/WB stage:
// write-back source select and load width/sign codes.
package core_pkg;

  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_MEM  = 2'b01;
  localparam logic [1:0] WDSEL_PC4  = 2'b10;
  localparam logic [1:0] WDSEL_NONE = 2'b11;

  localparam logic [2:0] DMTYPE_W   = 3'b000;
  localparam logic [2:0] DMTYPE_H   = 3'b001;
  localparam logic [2:0] DMTYPE_HU  = 3'b010;
  localparam logic [2:0] DMTYPE_B   = 3'b011;
  localparam logic [2:0] DMTYPE_BU  = 3'b100;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// valid and payload stay put until that transfer, and ready never looks at valid of the same side.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;

  logic w_accept;
  logic w_consume;
  logic w_main_valid_nx;
  logic w_skid_valid_nx;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  // in_ready comes straight from a flop, so it cannot depend on out_ready.
  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_consume = r_main_valid & out_ready;

  always_comb begin
    w_main_valid_nx  = r_main_valid;
    w_skid_valid_nx  = r_skid_valid;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_main_valid_nx = 1'b0;
      w_skid_valid_nx = 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        w_main_valid_nx = 1'b1;
        w_load_main_in  = 1'b1;
      end
    end else if (w_consume) begin
      // Skid entry is older than anything arriving now, so it goes first.
      if (r_skid_valid) begin
        w_load_main_skid = 1'b1;
        w_skid_valid_nx  = 1'b0;
      end else if (w_accept) begin
        w_load_main_in = 1'b1;
      end else begin
        w_main_valid_nx = 1'b0;
      end
    end else if (w_accept) begin
      w_load_skid     = 1'b1;
      w_skid_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else begin
      r_main_valid <= w_main_valid_nx;
      r_skid_valid <= w_skid_valid_nx;
      if (w_load_main_in) begin
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage_skid.sv
// MEM/WB pipeline stage: resolves the write-back value on the MEM side and
// registers {rd, regwrite, wb_data, pc} through a skid buffer so WB may stall.
module mem_wb_stage_skid
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_regwrite,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_dm,
  input  logic [2:0]       in_dmtype,
  input  logic [1:0]       in_wdsel,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_rd,
  output logic             out_regwrite,
  output logic [XLEN-1:0]  out_wb_data,
  output logic [XLEN-1:0]  out_pc
);

  localparam int PW = REG_W + 1 + 2 * XLEN;

  logic [XLEN-1:0] w_load_ext;
  logic [XLEN-1:0] w_wb_data;
  logic [PW-1:0]   w_in_payload;
  logic [PW-1:0]   w_out_payload;
  logic            w_out_rw;

  always_comb begin
    w_load_ext = in_dm;
    case (in_dmtype)
      DMTYPE_H:  w_load_ext = {{(XLEN-16){in_dm[15]}}, in_dm[15:0]};
      DMTYPE_HU: w_load_ext = {{(XLEN-16){1'b0}},      in_dm[15:0]};
      DMTYPE_B:  w_load_ext = {{(XLEN-8){in_dm[7]}},   in_dm[7:0]};
      DMTYPE_BU: w_load_ext = {{(XLEN-8){1'b0}},       in_dm[7:0]};
      default:   w_load_ext = in_dm;
    endcase
  end

  always_comb begin
    w_wb_data = '0;
    case (in_wdsel)
      WDSEL_ALU: w_wb_data = in_alu;
      WDSEL_MEM: w_wb_data = w_load_ext;
      WDSEL_PC4: w_wb_data = in_pc + XLEN'(4);
      default:   w_wb_data = '0;
    endcase
  end

  assign w_in_payload = {in_rd, in_regwrite, w_wb_data, in_pc};

  pipe_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_payload)
  );

  assign {out_rd, w_out_rw, out_wb_data, out_pc} = w_out_payload;

  // x0 is hard-wired zero, so a write to it is never issued.
  assign out_regwrite = w_out_rw & out_valid & (out_rd != '0);

endmodule

// File: tb/tb_mem_wb_stage_skid.sv
// Directed self-checking bench for mem_wb_stage_skid: write-back select,
// load extension, backpressure ordering, flush and reset behaviour.
module tb_mem_wb_stage_skid;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [REG_W-1:0] in_rd;
  logic             in_regwrite;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_dm;
  logic [2:0]       in_dmtype;
  logic [1:0]       in_wdsel;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [REG_W-1:0] out_rd;
  logic             out_regwrite;
  logic [XLEN-1:0]  out_wb_data;
  logic [XLEN-1:0]  out_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [REG_W+XLEN-1:0] exp_q[$];
  bit                    sb_on = 1'b0;

  mem_wb_stage_skid #(
    .XLEN  (XLEN),
    .REG_W (REG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .in_alu       (in_alu),
    .in_dm        (in_dm),
    .in_dmtype    (in_dmtype),
    .in_wdsel     (in_wdsel),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite),
    .out_wb_data  (out_wb_data),
    .out_pc       (out_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                        input logic [31:0] dm, input logic [2:0] dmt, input logic [1:0] ws,
                        input logic [31:0] pc);
    in_rd       = rd;
    in_regwrite = rw;
    in_alu      = alu;
    in_dm       = dm;
    in_dmtype   = dmt;
    in_wdsel    = ws;
    in_pc       = pc;
  endtask

  task automatic one(input string tag, input logic [31:0] exp_wb, input logic [4:0] exp_rd,
                     input logic exp_rw, input logic [31:0] exp_pc);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_wb"}, 64'(out_wb_data), 64'(exp_wb));
    check_eq({tag, "_rd"}, 64'(out_rd), 64'(exp_rd));
    check_eq({tag, "_rw"}, 64'(out_regwrite), 64'(exp_rw));
    check_eq({tag, "_pc"}, 64'(out_pc), 64'(exp_pc));
    step();
    check_eq({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  // scoreboard: every consume must match the oldest accepted entry
  always @(negedge clk) begin
    if (sb_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_extra", 64'd1, 64'd0);
      end else begin
        check_eq("sb_order", 64'({out_rd, out_wb_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_in(5'd9, 1'b1, 32'hCAFE_0001, 32'h0, 3'd0, 2'b00, 32'h0);
    step();
    step();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_wb_data", 64'(out_wb_data), 64'd0);
    check_eq("rst_regwrite", 64'(out_regwrite), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    step();
    check_eq("post_rst_idle", 64'(out_valid), 64'd0);

    set_in(5'd5, 1'b1, 32'h0000_1234, 32'h0, 3'd0, 2'b00, 32'h100);
    one("alu", 32'h0000_1234, 5'd5, 1'b1, 32'h100);

    set_in(5'd3, 1'b1, 32'hDEAD, 32'h0000_80F0, 3'b001, 2'b01, 32'h200);
    one("lh", 32'hFFFF_80F0, 5'd3, 1'b1, 32'h200);
    set_in(5'd3, 1'b1, 32'hDEAD, 32'h0000_80F0, 3'b010, 2'b01, 32'h204);
    one("lhu", 32'h0000_80F0, 5'd3, 1'b1, 32'h204);
    set_in(5'd3, 1'b1, 32'hDEAD, 32'h0000_80F0, 3'b011, 2'b01, 32'h208);
    one("lb", 32'hFFFF_FFF0, 5'd3, 1'b1, 32'h208);
    set_in(5'd3, 1'b1, 32'hDEAD, 32'h0000_80F0, 3'b100, 2'b01, 32'h20C);
    one("lbu", 32'h0000_00F0, 5'd3, 1'b1, 32'h20C);
    set_in(5'd4, 1'b1, 32'hDEAD, 32'h1234_80F0, 3'b000, 2'b01, 32'h210);
    one("lw", 32'h1234_80F0, 5'd4, 1'b1, 32'h210);
    set_in(5'd4, 1'b1, 32'hDEAD, 32'h8765_80F0, 3'b111, 2'b01, 32'h214);
    one("ld_rsvd", 32'h8765_80F0, 5'd4, 1'b1, 32'h214);

    set_in(5'd7, 1'b1, 32'h0, 32'h0, 3'd0, 2'b10, 32'hFFFF_FFFC);
    one("pc4_wrap", 32'h0000_0000, 5'd7, 1'b1, 32'hFFFF_FFFC);
    set_in(5'd8, 1'b1, 32'hAAAA, 32'h5555, 3'd0, 2'b11, 32'h40);
    one("wdsel_zero", 32'h0, 5'd8, 1'b1, 32'h40);
    set_in(5'd0, 1'b1, 32'h99, 32'h0, 3'd0, 2'b00, 32'h44);
    one("rd_zero", 32'h99, 5'd0, 1'b0, 32'h44);
    set_in(5'd12, 1'b0, 32'h77, 32'h0, 3'd0, 2'b00, 32'h48);
    one("no_rw", 32'h77, 5'd12, 1'b0, 32'h48);

    // backpressure: A to main, B to skid, C held off
    out_ready = 1'b0;
    sb_on     = 1'b1;
    in_valid  = 1'b1;
    set_in(5'd1, 1'b1, 32'h1111_1111, 32'h0, 3'd0, 2'b00, 32'h300);
    exp_q.push_back({5'd1, 32'h1111_1111});
    step();
    check_eq("bp_a_valid", 64'(out_valid), 64'd1);
    check_eq("bp_a_ready", 64'(in_ready), 64'd1);
    set_in(5'd2, 1'b1, 32'h0, 32'h0000_0080, 3'b011, 2'b01, 32'h304);
    exp_q.push_back({5'd2, 32'hFFFF_FF80});
    step();
    check_eq("bp_skid_full", 64'(in_ready), 64'd0);
    check_eq("bp_main_a", 64'(out_wb_data), 64'h1111_1111);
    set_in(5'd3, 1'b1, 32'h0, 32'h0, 3'd0, 2'b10, 32'h0000_1000);
    step();
    check_eq("bp_c_held", 64'(in_ready), 64'd0);
    check_eq("bp_stable", 64'(out_wb_data), 64'h1111_1111);
    step();
    check_eq("bp_stable_rd", 64'(out_rd), 64'd1);
    out_ready = 1'b1;
    step();
    check_eq("bp_main_b", 64'(out_wb_data), 64'hFFFF_FF80);
    check_eq("bp_ready_back", 64'(in_ready), 64'd1);
    exp_q.push_back({5'd3, 32'h0000_1004});
    step();
    in_valid = 1'b0;
    check_eq("bp_main_c", 64'(out_wb_data), 64'h0000_1004);
    step();
    step();
    sb_on = 1'b0;
    check_eq("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    check_eq("bp_idle", 64'(out_valid), 64'd0);

    // flush with both entries full, accept and consume requested
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(5'd10, 1'b1, 32'hA0A0_A0A0, 32'h0, 3'd0, 2'b00, 32'h400);
    step();
    set_in(5'd11, 1'b1, 32'hB0B0_B0B0, 32'h0, 3'd0, 2'b00, 32'h404);
    step();
    set_in(5'd13, 1'b1, 32'hC0C0_C0C0, 32'h0, 3'd0, 2'b00, 32'h408);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl2_valid", 64'(out_valid), 64'd0);
    check_eq("fl2_ready", 64'(in_ready), 64'd1);
    check_eq("fl2_regwrite", 64'(out_regwrite), 64'd0);
    check_eq("fl2_payload_hold", 64'(out_wb_data), 64'hA0A0_A0A0);
    step();
    check_eq("fl2_stays_empty", 64'(out_valid), 64'd0);

    // flush with one entry held and a real accept at the same edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(5'd14, 1'b1, 32'hD0D0_D0D0, 32'h0, 3'd0, 2'b00, 32'h500);
    step();
    set_in(5'd15, 1'b1, 32'hE0E0_E0E0, 32'h0, 3'd0, 2'b00, 32'h504);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl1_valid", 64'(out_valid), 64'd0);
    check_eq("fl1_ready", 64'(in_ready), 64'd1);
    check_eq("fl1_payload_hold", 64'(out_wb_data), 64'hD0D0_D0D0);

    // asynchronous reset in the middle of a stalled transfer
    in_valid = 1'b1;
    set_in(5'd16, 1'b1, 32'h1234_5678, 32'h0, 3'd0, 2'b00, 32'h600);
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_ready", 64'(in_ready), 64'd1);
    check_eq("arst_regwrite", 64'(out_regwrite), 64'd0);
    check_eq("arst_wb_data", 64'(out_wb_data), 64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("arst_no_wb", 64'(out_valid), 64'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
